vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/plot_pkg.sv | 15 +
 rtl/rr_select.sv | 28 ++
 rtl/vga_plot_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared state type and screen constants for the sprite plot arbiter
package plot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } plot_state_e;

    localparam int unsigned SCREEN_W     = 160;
    localparam int unsigned SCREEN_H     = 120;
    localparam logic [2:0]  COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick starting one past the last owner
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sel    = '0;
        // Scan from last_owner+1 around the ring; the first set bit wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - arbitrates sprite requesters onto a single VGA adapter plot port
module vga_plot_arbiter
    import plot_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int SPRITE_DIM = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_erase,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             colour_out,
    output logic                   writeEn,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (SPRITE_DIM > 1) ? $clog2(SPRITE_DIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPRITE_DIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    plot_state_e        state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [7:0]         base_x_q, base_x_d;
    logic [6:0]         base_y_q, base_y_d;
    logic [2:0]         colour_q, colour_d;
    logic [CNT_W-1:0]   cx_q, cx_d;
    logic [CNT_W-1:0]   cy_q, cy_d;

    logic [NUM_REQ-1:0] rr_winner;
    logic               rr_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         own_x;
    logic [6:0]         own_y;
    logic [2:0]         own_colour;
    logic               own_erase;
    logic [8:0]         sum_x;
    logic [7:0]         sum_y;
    logic               clip;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (rr_winner),
        .valid      (rr_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_winner[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Owner's input slices, selected by the registered owner index.
    always_comb begin
        own_x      = '0;
        own_y      = '0;
        own_colour = '0;
        own_erase  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_x      = req_x[8*i +: 8];
                own_y      = req_y[7*i +: 7];
                own_colour = req_colour[3*i +: 3];
                own_erase  = req_erase[i];
            end
        end
    end

    // One bit wider than the screen coordinate so off-screen pixels are detectable.
    assign sum_x = 9'(base_x_q) + 9'(cx_q);
    assign sum_y = 8'(base_y_q) + 8'(cy_q);
    assign clip  = (sum_x >= 9'(SCREEN_W)) || (sum_y >= 8'(SCREEN_H));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        colour_d     = colour_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        done         = '0;
        writeEn      = 1'b0;
        x_out        = '0;
        y_out        = '0;
        colour_out   = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    grant_d = rr_winner;
                    owner_d = win_idx;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                base_x_d = own_x;
                base_y_d = own_y;
                colour_d = own_erase ? COLOUR_BLACK : own_colour;
                cx_d     = '0;
                cy_d     = '0;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                x_out      = sum_x[7:0];
                y_out      = sum_y[6:0];
                colour_out = colour_q;
                writeEn    = !clip;
                cx_d       = cx_q + CNT_W'(1);
                if (cx_q == CNT_LAST) begin
                    cx_d = '0;
                    cy_d = cy_q + CNT_W'(1);
                    if (cy_q == CNT_LAST) begin
                        cy_d    = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done         = grant_q;
                last_owner_d = owner_q;
                grant_d      = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_LAST;
            base_x_q     <= '0;
            base_y_q     <= '0;
            colour_q     <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            colour_q     <= colour_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - randomized and directed bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_erase;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [3*N-1:0] req_colour;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [7:0]     x_out;
    logic [6:0]     y_out;
    logic [2:0]     colour_out;
    logic           writeEn;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int model_last;

    vga_plot_arbiter #(
        .NUM_REQ    (N),
        .SPRITE_DIM (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_erase  (req_erase),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .writeEn    (writeEn),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y, input int col, input bit erase);
        req[i]                = 1'b1;
        req_x[8*i +: 8]       = 8'(x);
        req_y[7*i +: 7]       = 7'(y);
        req_colour[3*i +: 3]  = 3'(col);
        req_erase[i]          = erase;
    endtask

    task automatic raise_random(input int i);
        int x;
        int y;
        x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 159)) : int'($urandom_range(0, 152));
        y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(112, 127)) : int'($urandom_range(0, 112));
        set_req(i, x, y, int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    endtask

    // Reference arbitration: first requester found scanning upward from last owner + 1.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    // Entered at +1 after an edge with the DUT idle; the next edge samples req.
    task automatic serve_one(input bit keep, input bit perturb, input bit raise_mid);
        int w, bx, by, col, ex, ey, ri;
        bit ewe;
        w = model_pick(req);
        if (w < 0) return;
        bx  = int'(req_x[8*w +: 8]);
        by  = int'(req_y[7*w +: 7]);
        col = req_erase[w] ? 0 : int'(req_colour[3*w +: 3]);

        @(posedge clk); #1;
        check("grant_latch", grant, 32'(1 << w));
        check("busy_latch", busy, 1);
        check("we_latch", writeEn, 0);

        @(posedge clk); #1;
        if (perturb) begin
            if (!keep) req[w] = 1'b0;
            req_x[8*w +: 8]      = 8'($urandom);
            req_y[7*w +: 7]      = 7'($urandom);
            req_colour[3*w +: 3] = 3'($urandom);
            req_erase[w]         = ~req_erase[w];
        end

        for (int k = 0; k < D*D; k++) begin
            ex  = bx + k % D;
            ey  = by + k / D;
            ewe = (ex < 160) && (ey < 120);
            check($sformatf("x_out[%0d]", k), x_out, ex % 256);
            check($sformatf("y_out[%0d]", k), y_out, ey % 128);
            check($sformatf("colour[%0d]", k), colour_out, col);
            check($sformatf("we[%0d]", k), writeEn, ewe);
            check($sformatf("grant_draw[%0d]", k), grant, 32'(1 << w));
            check($sformatf("done_draw[%0d]", k), done, 0);
            if (raise_mid && k == 10) begin
                ri = int'($urandom_range(0, N-1));
                if (!req[ri] && ri != w) raise_random(ri);
            end
            @(posedge clk); #1;
        end

        check("done_pulse", done, 32'(1 << w));
        check("we_done", writeEn, 0);
        check("x_done", x_out, 0);
        check("busy_done", busy, 1);
        model_last = w;
        if (!keep) req[w] = 1'b0;

        @(posedge clk); #1;
        check("done_clear", done, 0);
        check("grant_idle", grant, 0);
        check("busy_idle", busy, 0);
        check("we_idle", writeEn, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_erase  = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        model_last = N - 1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_we", writeEn, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_colour", colour_out, 0);

        // Request present as reset releases: must be taken on the first edge.
        set_req(0, 10, 20, 5, 1'b0);
        reset = 1'b0;
        serve_one(1'b0, 1'b0, 1'b0);

        set_req(2, 40, 50, 7, 1'b1);
        serve_one(1'b0, 1'b0, 1'b0);

        set_req(1, 156, 116, 3, 1'b0);
        serve_one(1'b0, 1'b0, 1'b0);

        set_req(0, 70, 60, 2, 1'b0);
        serve_one(1'b0, 1'b1, 1'b0);

        // Reset during the 30th DRAW cycle of requester 1.
        set_req(1, 30, 40, 6, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_grant_latch", grant, 32'(1 << model_pick(req)));
        @(posedge clk); #1;
        repeat (29) @(posedge clk);
        #1;
        check("rst_mid_we_before", writeEn, 1);
        check("rst_mid_x_before", x_out, 30 + 29 % D);
        check("rst_mid_y_before", y_out, 40 + 29 / D);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we", writeEn, 0);
        check("rst_mid_grant", grant, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_x", x_out, 0);
        check("rst_mid_done", done, 0);
        req = '0;
        set_req(3, 100, 90, 4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset      = 1'b0;
        model_last = N - 1;
        serve_one(1'b0, 1'b0, 1'b0);

        // All requesters held continuously: one grant each per rotation.
        for (int i = 0; i < N; i++) set_req(i, 20 * i, 10 * i, i + 1, 1'b0);
        for (int s = 0; s < N + 1; s++) serve_one(1'b1, 1'b0, 1'b0);
        req = '0;

        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) raise_random(i);
            end
            if (req == '0) raise_random(int'($urandom_range(0, N-1)));
            serve_one(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
